// File: rtl/float_mul_seq_pkg.sv
// float_pack: float format, multiplier constants, state and mantissa types
package float_pack;
  localparam int N_mantisse = 20;
  localparam int N_exposant = 4;
  localparam int FLOAT_BIAS = 2 ** (N_exposant - 1) - 1;
  localparam int FLOAT_EXP_MAX = 2 ** N_exposant - 2;
  typedef struct packed {
    logic signe;
    logic [N_exposant-1:0] exposant;
    logic [N_mantisse-1:0] mantisse;
  } float;
  typedef logic [N_mantisse:0] float_mant_ext;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} float_mul_state_t;
endpackage

// File: rtl/float_mul_seq_if.sv
// float_mul_seq_if: operand and result valid/ready channels of the float multiplier
interface float_mul_seq_if;
  import float_pack::*;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, ovf_o, unf_o;
  float a_i, b_i, result_o;
  modport master(
    output in_valid_i, a_i, b_i, out_ready_i,
    input in_ready_o, out_valid_o, result_o, ovf_o, unf_o
  );
  modport slave(
    input in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, ovf_o, unf_o
  );
endinterface

// File: rtl/float_mant_mul_seq.sv
// float_mant_mul_seq: shift-add mantissa multiplier, one multiplier bit per cycle
module float_mant_mul_seq
  import float_pack::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  float_mant_ext ma,
  input  float_mant_ext mb,
  output logic done,
  output logic [2*N_mantisse+1:0] prod
);
  localparam int PW = 2 * (N_mantisse + 1);
  localparam int CW = $clog2(N_mantisse + 1);
  logic [PW-1:0] acc;
  float_mant_ext mr;
  logic [CW-1:0] cnt;
  logic busy;
  // done marks the cycle whose edge performs the final partial-product add
  assign done = busy && cnt == CW'(N_mantisse);
  always_ff @(posedge clk_i)
    if (rst_i) begin
      acc <= '0;
      mr <= '0;
      cnt <= '0;
      busy <= 1'b0;
      prod <= '0;
    end else if (start) begin
      acc <= PW'(ma);
      mr <= mb;
      cnt <= '0;
      busy <= 1'b1;
      prod <= '0;
    end else if (busy) begin
      prod <= prod + (mr[0] ? acc : '0);
      acc <= acc << 1;
      mr <= mr >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/float_mul_seq.sv
// float_mul_seq: iterative float multiplier with saturation, flush-to-zero and truncation
module float_mul_seq
  import float_pack::*;
(
  input logic clk_i,
  input logic rst_i,
  float_mul_seq_if.slave bus
);
  localparam int PW = 2 * (N_mantisse + 1);
  localparam int EW = N_exposant + 2;
  float_mul_state_t state;
  logic sign, start, done, zero_op, sat, flush, unused_bits;
  logic [N_exposant-1:0] ea, eb;
  logic [PW-1:0] prod;
  logic signed [EW-1:0] e_norm;
  logic [N_mantisse-1:0] m_norm;
  assign zero_op = bus.a_i.exposant == '0 || bus.b_i.exposant == '0;
  assign start = bus.in_ready_o && bus.in_valid_i && !zero_op;
  float_mant_mul_seq u_core (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start(start),
    .ma({1'b1, bus.a_i.mantisse}),
    .mb({1'b1, bus.b_i.mantisse}),
    .done(done),
    .prod(prod)
  );
  assign e_norm = EW'(ea) + EW'(eb) + EW'(prod[PW-1]) - EW'(FLOAT_BIAS);
  assign m_norm = prod[PW-1] ? prod[PW-2 -: N_mantisse] : prod[PW-3 -: N_mantisse];
  // an all-ones exponent field is reserved and forces saturation
  assign sat = &ea || &eb || e_norm > $signed(EW'(FLOAT_EXP_MAX));
  assign flush = e_norm < $signed(EW'(1));
  assign unused_bits = ^prod[PW-N_mantisse-3:0];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      bus.in_ready_o <= 1'b1;
      bus.out_valid_o <= 1'b0;
      bus.result_o <= '0;
      bus.ovf_o <= 1'b0;
      bus.unf_o <= 1'b0;
      sign <= 1'b0;
      ea <= '0;
      eb <= '0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid_i) begin
            sign <= bus.a_i.signe ^ bus.b_i.signe;
            ea <= bus.a_i.exposant;
            eb <= bus.b_i.exposant;
            bus.in_ready_o <= 1'b0;
            bus.out_valid_o <= zero_op;
            bus.result_o <= {bus.a_i.signe ^ bus.b_i.signe, {N_exposant{1'b0}}, {N_mantisse{1'b0}}};
            bus.ovf_o <= 1'b0;
            bus.unf_o <= 1'b0;
            state <= zero_op ? DONE : MUL;
          end
        MUL: state <= done ? NORM : MUL;
        NORM: begin
          bus.out_valid_o <= 1'b1;
          bus.ovf_o <= sat;
          bus.unf_o <= !sat && flush;
          bus.result_o <= sat ? {sign, N_exposant'(FLOAT_EXP_MAX), {N_mantisse{1'b1}}}
                        : {sign, flush ? {N_exposant{1'b0}} : e_norm[N_exposant-1:0],
                           flush ? {N_mantisse{1'b0}} : m_norm};
          state <= DONE;
        end
        DONE:
          if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
            bus.in_ready_o <= 1'b1;
            state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_float_mul_seq.sv
// tb_float_mul_seq: directed vectors into a scoreboard, checked by an independent monitor
module tb_float_mul_seq;
  import float_pack::*;
  typedef struct {
    float r;
    logic o;
    logic u;
    int lat;
  } exp_t;
  logic clk, rst;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  exp_t exp_q[$];
  int acc_q[$];
  float_mul_seq_if bus();
  float_mul_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic float fp(input logic s, input logic [N_exposant-1:0] e, input logic [N_mantisse-1:0] m);
    return {s, e, m};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic issue(input float a, input float b, input float r, input logic o, input logic u,
                       input int lat, input int stall, input bit track);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready_o) begin
      chk("in_ready_timeout", 32'(bus.in_ready_o), 32'd1);
      return;
    end
    bus.a_i = a;
    bus.b_i = b;
    bus.in_valid_i = 1'b1;
    stall_cnt = stall;
    if (track) begin
      exp_q.push_back('{r, o, u, lat});
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.a_i = float'($urandom);
    bus.b_i = float'($urandom);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid_o && stall_cnt > 0) begin
        bus.out_ready_i = 1'b0;
        stall_cnt--;
      end else bus.out_ready_i = 1'b1;
    end
  end
  initial begin
    exp_t cur;
    int c0;
    bit in_flight = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) in_flight = 0;
      else if (bus.out_valid_o && !in_flight) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          cur = exp_q.pop_front();
          c0 = acc_q.pop_front();
          in_flight = 1;
          chk("result", 32'(bus.result_o), 32'(cur.r));
          chk("ovf", 32'(bus.ovf_o), 32'(cur.o));
          chk("unf", 32'(bus.unf_o), 32'(cur.u));
          chk("latency", 32'(cyc - c0 + 1), 32'(cur.lat));
        end
      end else if (bus.out_valid_o) begin
        chk("hold_result", 32'(bus.result_o), 32'(cur.r));
        chk("hold_ovf", 32'(bus.ovf_o), 32'(cur.o));
        chk("hold_in_ready", 32'(bus.in_ready_o), 32'd0);
      end else in_flight = 0;
    end
  end
  initial begin
    int n = 0;
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_result", 32'(bus.result_o), 32'd0);
    chk("rst_ovf_unf", {30'd0, bus.ovf_o, bus.unf_o}, 32'd0);
    rst = 1'b0;
    issue(fp(0, 7, 20'h80000), fp(0, 7, 20'h80000), fp(0, 8, 20'h20000), 0, 0, 23, 0, 1);
    issue(fp(1, 7, 20'h80000), fp(0, 8, 20'h00000), fp(1, 8, 20'h80000), 0, 0, 23, 5, 1);
    issue(fp(0, 13, 20'h0), fp(0, 13, 20'h0), fp(0, 14, 20'hFFFFF), 1, 0, 23, 0, 1);
    issue(fp(0, 3, 20'h0), fp(0, 3, 20'h0), fp(0, 0, 20'h0), 0, 1, 23, 2, 1);
    issue(fp(0, 0, 20'h0), fp(0, 9, 20'h40000), fp(0, 0, 20'h0), 0, 0, 1, 0, 1);
    issue(fp(0, 14, 20'h0), fp(0, 7, 20'h0), fp(0, 14, 20'h0), 0, 0, 23, 0, 1);
    issue(fp(0, 4, 20'h0), fp(0, 4, 20'h0), fp(0, 1, 20'h0), 0, 0, 23, 1, 1);
    issue(fp(0, 15, 20'h0), fp(0, 1, 20'h0), fp(0, 14, 20'hFFFFF), 1, 0, 23, 0, 1);
    issue(fp(1, 15, 20'h0), fp(0, 0, 20'h5), fp(1, 0, 20'h0), 0, 0, 1, 3, 1);
    issue(fp(0, 7, 20'hFFFFF), fp(0, 7, 20'hFFFFF), fp(0, 8, 20'hFFFFE), 0, 0, 23, 0, 1);
    issue(fp(1, 8, 20'h40000), fp(1, 6, 20'h0), fp(0, 7, 20'h40000), 0, 0, 23, 0, 1);
    issue(fp(0, 7, 20'h80000), fp(0, 7, 20'h80000), fp(0, 8, 20'h20000), 0, 0, 23, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst_result", 32'(bus.result_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(fp(0, 8, 20'h0), fp(0, 8, 20'h80000), fp(0, 9, 20'h80000), 0, 0, 23, 0, 1);
    while ((exp_q.size() != 0 || bus.out_valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_mul_seq.md
Name: float_mul_seq

Overview:
- Iterative floating-point multiplier; consumes the packed `float` operands produced by the real↔float conversion stage of the coprocessor.
- Returns a packed `float` product to the coprocessor result path.
- Uses valid/ready handshakes on both sides and a shift-add mantissa datapath, one bit per cycle, to keep area small.
- Number semantics match the conversion rules: exponent field 0 means zero, maximum legal exponent field is 2^N_exposant−2, saturation on overflow, flush-to-zero on underflow, truncation rounding.

Parameters:
- N_mantisse, 20, mantissa field width (1..23); taken from float_pack, not redeclared.
- N_exposant, 4, exponent field width (2..8); taken from float_pack.
- W = 1+N_exposant+N_mantisse (25), derived operand width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operands (high only in IDLE).
- a_i  in  W  operand A, float_pack::float.
- b_i  in  W  operand B, float_pack::float.
- out_valid_o  out  1  result_o valid; held until accepted.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  W  product, float_pack::float, registered.
- ovf_o  out  1  result saturated; qualified by out_valid_o.
- unf_o  out  1  result flushed to zero by underflow (not by a zero operand); qualified by out_valid_o.

Behaviour:
- Reset: state=IDLE; in_ready_o=1; out_valid_o=0; result_o=0; ovf_o=0; unf_o=0; accumulator and counter cleared. Reset wins over every other event on the same edge, including mid-MUL and DONE (the in-flight operation is discarded, nothing emitted).
- Constants: BIAS=2^(N_exposant−1)−1 (7); EXP_MAX=2^N_exposant−2 (14).
- Accept: a handshake occurs on the edge where in_valid_i && in_ready_o. On that edge the block latches sign=a.signe^b.signe, ea, eb, ma={1,a.mantisse} and mb={1,b.mantisse} (N_mantisse+1 bits each).
- IDLE→ZERO path: if ea==0 or eb==0, go straight to DONE on the accept edge with result {sign,0,0}, ovf=0, unf=0. out_valid_o is high on the next cycle (latency 1).
- IDLE→MUL: otherwise. MUL runs exactly N_mantisse+1 cycles (21). Each cycle: if the current mb bit is 1, add ma shifted into the 2(N_mantisse+1)-bit product P; advance the counter. Shift-add order is free, but P must be exact.
- MUL→NORM: when the counter reaches N_mantisse. NORM takes 1 cycle:
  - If P[MSB]=1: m=P[MSB−1 -: N_mantisse] and E=ea+eb−BIAS+1.
  - Else: m=P[MSB−2 -: N_mantisse] and E=ea+eb−BIAS.
  - Lower bits are truncated.
  - E is computed signed, at least N_exposant+2 bits wide.
- Range rules, applied in NORM and registered into result_o:
  - E>EXP_MAX: result={sign,EXP_MAX,all ones}, ovf=1.
  - E<1: result={sign,0,0}, unf=1.
  - Otherwise: {sign,E[N_exposant−1:0],m}.
- An operand exponent field of all ones (reserved) is treated as EXP_MAX+1; this always saturates unless the other operand is zero.
- NORM→DONE. Normal-path latency: out_valid_o is high 23 cycles after the accept edge (1 latch + 21 MUL + 1 NORM).
- DONE: out_valid_o=1; result_o, ovf_o and unf_o stay stable while out_valid_o && !out_ready_i. When out_ready_i=1, the next state is IDLE and out_valid_o drops the following cycle.
- in_ready_o=0 in MUL, NORM and DONE. There is no overlap: the next operands are accepted, at the earliest, the cycle after the result handshake.
- Changes on a_i/b_i outside an accept edge have no effect.

Decomposition:
- float_pack gains:
  - constants FLOAT_BIAS and FLOAT_EXP_MAX, derived from N_exposant;
  - enum float_mul_state_t {IDLE, MUL, NORM, DONE};
  - typedef float_mant_ext (N_mantisse+1 bits).
- One sub-module: float_mant_mul_seq, the shift-add mantissa core with start/done, 2(N_mantisse+1)-bit product output, and the same clk_i/rst_i.
- The FSM, exponent arithmetic, normalisation and handshake stay in float_mul_seq.

Test Plan:
- 1.5×1.5: a={0,7,0x80000}, b=same → result {0,8,0x20000} (2.25), ovf=unf=0, out_valid exactly 23 cycles after accept.
- −1.5×2.0: a={1,7,0x80000}, b={0,8,0} → result {1,8,0x80000} (−3.0); with out_ready_i held low for 5 cycles, result stays stable and in_ready_o stays 0 throughout.
- Overflow 64×64: a=b={0,13,0} → result {0,14,0xFFFFF}, ovf=1. Underflow 2^-4×2^-4: a=b={0,3,0} → result {0,0,0}, unf=1.
- Zero shortcut: a={0,0,0}, b={0,9,0x40000} (5.0) → result {0,0,0}, unf=0, out_valid one cycle after accept.
- Reset mid-MUL: assert rst_i 10 cycles after accept → next cycle in_ready_o=1, out_valid_o=0, result_o=0; a following 2.0×3.0 ({0,8,0}×{0,8,0x80000}) → {0,9,0x80000} with no stale data.
- Random regression: 10k operand pairs with random out_ready_i stalls, compared against a shortreal model that uses the float_pack conversion functions; bit-exact result, ovf and unf required.
